// File: rtl/rob_ctrl.sv
// ---------------------------------------------------------------------------
// rob_ctrl
//
// Purpose:
//    Allocation / completion / commit controller for the reorder buffer
//    storage. Owns the circular head/tail pointers and the per-entry busy and
//    done bits. It drives the two storage write ports (wr1 for allocation,
//    wr2 for completion) and reads the head entry through rd1 so that entries
//    can retire in program order.
//
// Optional feature:
//    QU_ROB_STALL_CNT_EN - when defined, stall_cnt counts the cycles in which
//    dispatch wanted an entry but none was available (saturating, cleared
//    only by rst). When undefined, stall_cnt is tied to zero.
//
// Ports:
//    clk, rst          clock, synchronous active-high reset
//    alloc_valid/ready dispatch handshake; alloc_data is the initial cell,
//                      alloc_tag is the index that will be granted
//    cpl_valid/tag/data completion from the execution units
//    commit_valid/ready in-order retire handshake; commit_tag/commit_data
//                      describe the head entry
//    flush             discard every entry
//    full/empty/count  occupancy status
//    stall_cnt         allocation stall counter (optional feature)
//    rob_wr1_*         storage write port used by allocation
//    rob_wr2_*         storage write port used by completion
//    rob_rd1_addr/out  storage read port (combinational read of head)
// ---------------------------------------------------------------------------
module rob_ctrl #(
   parameter int ROB_DEPTH = 32,
   parameter int CELL_W    = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alloc_valid,
   output logic                           alloc_ready,
   input  logic [CELL_W-1:0]              alloc_data,
   output logic [$clog2(ROB_DEPTH)-1:0]   alloc_tag,
   input  logic                           cpl_valid,
   input  logic [$clog2(ROB_DEPTH)-1:0]   cpl_tag,
   input  logic [CELL_W-1:0]              cpl_data,
   output logic                           commit_valid,
   input  logic                           commit_ready,
   output logic [$clog2(ROB_DEPTH)-1:0]   commit_tag,
   output logic [CELL_W-1:0]              commit_data,
   input  logic                           flush,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(ROB_DEPTH):0]     count,
   output logic [31:0]                    stall_cnt,
   output logic                           rob_wr1_en,
   output logic [$clog2(ROB_DEPTH)-1:0]   rob_wr1_addr,
   output logic [CELL_W-1:0]              rob_wr1_in,
   output logic                           rob_wr2_en,
   output logic [$clog2(ROB_DEPTH)-1:0]   rob_wr2_addr,
   output logic [CELL_W-1:0]              rob_wr2_in,
   output logic [$clog2(ROB_DEPTH)-1:0]   rob_rd1_addr,
   input  logic [CELL_W-1:0]              rob_rd1_out
);

   localparam int AW    = $clog2(ROB_DEPTH);
   localparam int PTR_W = AW + 1;

   logic [PTR_W-1:0]     head;
   logic [PTR_W-1:0]     tail;
   logic [ROB_DEPTH-1:0] busy;
   logic [ROB_DEPTH-1:0] done;
   logic [AW-1:0]        head_idx;
   logic [AW-1:0]        tail_idx;
   logic                 alloc_fire;
   logic                 cpl_fire;
   logic                 commit_fire;

   assign head_idx = head[AW-1:0];
   assign tail_idx = tail[AW-1:0];

   // Occupancy: the extra pointer MSB is a wrap bit, so equal indices mean
   // empty when the wrap bits agree and full when they differ.
   assign empty = (head == tail);
   assign full  = (head_idx == tail_idx) && (head[PTR_W-1] != tail[PTR_W-1]);
   assign count = tail - head;

   // Handshakes. Flush masks everything; a full ROB refuses allocation even
   // when a commit frees the head in the same cycle.
   assign alloc_ready  = !full && !flush;
   assign alloc_fire   = alloc_valid && alloc_ready;
   assign cpl_fire     = cpl_valid && !flush && busy[cpl_tag] && !done[cpl_tag];
   assign commit_valid = !empty && done[head_idx] && !flush;
   assign commit_fire  = commit_valid && commit_ready;

   assign alloc_tag    = tail_idx;
   assign commit_tag   = head_idx;
   assign commit_data  = rob_rd1_out;
   assign rob_rd1_addr = head_idx;

   assign rob_wr1_en   = alloc_fire;
   assign rob_wr1_addr = tail_idx;
   assign rob_wr1_in   = alloc_data;
   assign rob_wr2_en   = cpl_fire;
   assign rob_wr2_addr = cpl_tag;
   assign rob_wr2_in   = cpl_data;

   // Pointer and per-entry state. Commit, allocation and completion never
   // touch the same entry in one cycle (commit needs done, completion needs
   // !done, allocation needs !busy), so their updates are independent.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head <= '0;
         tail <= '0;
         busy <= '0;
         done <= '0;
      end else begin
         if (commit_fire) begin
            busy[head_idx] <= 1'b0;
            done[head_idx] <= 1'b0;
            head           <= head + PTR_W'(1);
         end
         if (alloc_fire) begin
            busy[tail_idx] <= 1'b1;
            done[tail_idx] <= 1'b0;
            tail           <= tail + PTR_W'(1);
         end
         if (cpl_fire) begin
            done[cpl_tag] <= 1'b1;
         end
      end
   end

`ifdef QU_ROB_STALL_CNT_EN
   logic [31:0] stall_q;

   // Saturating stall counter; survives flush so it reflects the whole run.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (alloc_valid && !alloc_ready && !flush && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rob_ctrl
//
// Purpose:
//    Directed self-checking bench for rob_ctrl. A small behavioural storage
//    array stands in for the reorder buffer memory so commit_data reflects
//    what was actually written through wr1/wr2.
// ---------------------------------------------------------------------------
module tb_rob_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [31:0] alloc_data;
   logic [4:0]  alloc_tag;
   logic        cpl_valid;
   logic [4:0]  cpl_tag;
   logic [31:0] cpl_data;
   logic        commit_valid;
   logic        commit_ready;
   logic [4:0]  commit_tag;
   logic [31:0] commit_data;
   logic        flush;
   logic        full;
   logic        empty;
   logic [5:0]  count;
   logic [31:0] stall_cnt;
   logic        rob_wr1_en;
   logic [4:0]  rob_wr1_addr;
   logic [31:0] rob_wr1_in;
   logic        rob_wr2_en;
   logic [4:0]  rob_wr2_addr;
   logic [31:0] rob_wr2_in;
   logic [4:0]  rob_rd1_addr;
   logic [31:0] rob_rd1_out;

   logic [31:0] mem [32];

   int n_checks = 0;
   int n_fails  = 0;

`ifdef QU_ROB_STALL_CNT_EN
   localparam logic [31:0] STALL_EXP = 32'd4;
`else
   localparam logic [31:0] STALL_EXP = 32'd0;
`endif

   rob_ctrl #(.ROB_DEPTH(32), .CELL_W(32)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_data(alloc_data), .alloc_tag(alloc_tag),
      .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_tag(commit_tag), .commit_data(commit_data),
      .flush(flush), .full(full), .empty(empty), .count(count),
      .stall_cnt(stall_cnt),
      .rob_wr1_en(rob_wr1_en), .rob_wr1_addr(rob_wr1_addr), .rob_wr1_in(rob_wr1_in),
      .rob_wr2_en(rob_wr2_en), .rob_wr2_addr(rob_wr2_addr), .rob_wr2_in(rob_wr2_in),
      .rob_rd1_addr(rob_rd1_addr), .rob_rd1_out(rob_rd1_out)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Behavioural storage: two write ports, combinational read of the head.
   always @(posedge clk) begin
      if (rob_wr1_en) mem[rob_wr1_addr] <= rob_wr1_in;
      if (rob_wr2_en) mem[rob_wr2_addr] <= rob_wr2_in;
   end
   assign rob_rd1_out = mem[rob_rd1_addr];

   // Drive one cycle's worth of inputs; called just after a falling edge.
   task automatic applyStimulus(input logic av, input logic [31:0] ad,
                                input logic cv, input logic [4:0] ct, input logic [31:0] cd,
                                input logic cr, input logic fl);
      alloc_valid  = av;
      alloc_data   = ad;
      cpl_valid    = cv;
      cpl_tag      = ct;
      cpl_data     = cd;
      commit_ready = cr;
      flush        = fl;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_empty: got %0h want 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fails++; $display("FAIL reset_full: got %0h want 0", full); end
      n_checks++; if (count !== 6'd0) begin n_fails++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (alloc_ready !== 1'b1) begin n_fails++; $display("FAIL reset_alloc_ready: got %0h want 1", alloc_ready); end
      n_checks++; if (commit_valid !== 1'b0) begin n_fails++; $display("FAIL reset_commit_valid: got %0h want 0", commit_valid); end
      n_checks++; if (rob_wr1_en !== 1'b0 || rob_wr2_en !== 1'b0) begin n_fails++; $display("FAIL reset_wr_en: got %0h/%0h want 0/0", rob_wr1_en, rob_wr2_en); end
      n_checks++; if (stall_cnt !== 32'd0) begin n_fails++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
      @(negedge clk);
   endtask

   task automatic test_alloc();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'd5 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
         #1;
         n_checks++; if (alloc_tag !== 5'(i)) begin n_fails++; $display("FAIL alloc_tag[%0d]: got %0d want %0d", i, alloc_tag, i); end
         n_checks++; if (rob_wr1_en !== 1'b1 || rob_wr1_addr !== 5'(i) || rob_wr1_in !== 32'd5 + 32'(i)) begin
            n_fails++; $display("FAIL alloc_wr1[%0d]: got en=%0h addr=%0d data=%0d want 1/%0d/%0d", i, rob_wr1_en, rob_wr1_addr, rob_wr1_in, i, 5 + i);
         end
         @(negedge clk);
      end
      idle();
      #1;
      n_checks++; if (count !== 6'd3) begin n_fails++; $display("FAIL alloc_count: got %0d want 3", count); end
      n_checks++; if (commit_valid !== 1'b0) begin n_fails++; $display("FAIL alloc_commit_valid: got %0h want 0", commit_valid); end
      @(negedge clk);
   endtask

   task automatic test_completion();
      applyStimulus(1'b0, 32'd0, 1'b1, 5'd1, 32'd16, 1'b0, 1'b0);
      #1;
      n_checks++; if (rob_wr2_en !== 1'b1 || rob_wr2_addr !== 5'd1 || rob_wr2_in !== 32'd16) begin
         n_fails++; $display("FAIL cpl1_wr2: got en=%0h addr=%0d data=%0d want 1/1/16", rob_wr2_en, rob_wr2_addr, rob_wr2_in);
      end
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b1, 5'd0, 32'd15, 1'b0, 1'b0);
      #1;
      n_checks++; if (commit_valid !== 1'b0) begin n_fails++; $display("FAIL cpl_early_commit: got %0h want 0", commit_valid); end
      n_checks++; if (rob_wr2_en !== 1'b1 || rob_wr2_addr !== 5'd0 || rob_wr2_in !== 32'd15) begin
         n_fails++; $display("FAIL cpl0_wr2: got en=%0h addr=%0d data=%0d want 1/0/15", rob_wr2_en, rob_wr2_addr, rob_wr2_in);
      end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 5'd0 || commit_data !== 32'd15) begin
         n_fails++; $display("FAIL cpl_commit_ready: got v=%0h tag=%0d data=%0d want 1/0/15", commit_valid, commit_tag, commit_data);
      end
      @(negedge clk);
   endtask

   task automatic test_dropped_cpl();
      applyStimulus(1'b0, 32'd0, 1'b1, 5'd9, 32'd99, 1'b0, 1'b0);
      #1;
      n_checks++; if (rob_wr2_en !== 1'b0) begin n_fails++; $display("FAIL drop_not_busy: got wr2_en=%0h want 0", rob_wr2_en); end
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b1, 5'd0, 32'd99, 1'b0, 1'b0);
      #1;
      n_checks++; if (rob_wr2_en !== 1'b0) begin n_fails++; $display("FAIL drop_already_done: got wr2_en=%0h want 0", rob_wr2_en); end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (count !== 6'd3) begin n_fails++; $display("FAIL drop_count: got %0d want 3", count); end
      n_checks++; if (commit_data !== 32'd15) begin n_fails++; $display("FAIL drop_data: got %0d want 15", commit_data); end
      @(negedge clk);
   endtask

   task automatic test_commit();
      applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      #1;
      n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 5'd0 || commit_data !== 32'd15) begin
         n_fails++; $display("FAIL commit0: got v=%0h tag=%0d data=%0d want 1/0/15", commit_valid, commit_tag, commit_data);
      end
      @(negedge clk);
      #1;
      n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 5'd1 || commit_data !== 32'd16) begin
         n_fails++; $display("FAIL commit1: got v=%0h tag=%0d data=%0d want 1/1/16", commit_valid, commit_tag, commit_data);
      end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (commit_valid !== 1'b0 || commit_tag !== 5'd2) begin
         n_fails++; $display("FAIL commit_tag2_pending: got v=%0h tag=%0d want 0/2", commit_valid, commit_tag);
      end
      n_checks++; if (count !== 6'd1) begin n_fails++; $display("FAIL commit_count: got %0d want 1", count); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      // Allocate entry 3 while completing entry 2.
      applyStimulus(1'b1, 32'd8, 1'b1, 5'd2, 32'd20, 1'b0, 1'b0);
      #1;
      n_checks++; if (rob_wr1_en !== 1'b1 || rob_wr1_addr !== 5'd3 || rob_wr2_en !== 1'b1 || rob_wr2_addr !== 5'd2) begin
         n_fails++; $display("FAIL b2b_a_writes: got wr1=%0h@%0d wr2=%0h@%0d want 1@3 1@2", rob_wr1_en, rob_wr1_addr, rob_wr2_en, rob_wr2_addr);
      end
      @(negedge clk);
      // Allocate entry 4, complete entry 3 and commit entry 2 together.
      applyStimulus(1'b1, 32'd9, 1'b1, 5'd3, 32'd21, 1'b1, 1'b0);
      #1;
      n_checks++; if (commit_valid !== 1'b1 || commit_data !== 32'd20) begin
         n_fails++; $display("FAIL b2b_commit: got v=%0h data=%0d want 1/20", commit_valid, commit_data);
      end
      n_checks++; if (rob_wr1_en !== 1'b1 || rob_wr1_addr !== 5'd4 || rob_wr2_en !== 1'b1 || rob_wr2_addr !== 5'd3) begin
         n_fails++; $display("FAIL b2b_b_writes: got wr1=%0h@%0d wr2=%0h@%0d want 1@4 1@3", rob_wr1_en, rob_wr1_addr, rob_wr2_en, rob_wr2_addr);
      end
      n_checks++; if (count !== 6'd2) begin n_fails++; $display("FAIL b2b_count_before: got %0d want 2", count); end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (count !== 6'd2 || commit_tag !== 5'd3 || commit_valid !== 1'b1) begin
         n_fails++; $display("FAIL b2b_after: got count=%0d tag=%0d v=%0h want 2/3/1", count, commit_tag, commit_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_flush();
      applyStimulus(1'b1, 32'd33, 1'b1, 5'd4, 32'd44, 1'b1, 1'b1);
      #1;
      n_checks++; if (rob_wr1_en !== 1'b0 || rob_wr2_en !== 1'b0) begin n_fails++; $display("FAIL flush_writes: got %0h/%0h want 0/0", rob_wr1_en, rob_wr2_en); end
      n_checks++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b0) begin
         n_fails++; $display("FAIL flush_handshake: got ready=%0h cv=%0h want 0/0", alloc_ready, commit_valid);
      end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (empty !== 1'b1 || count !== 6'd0 || alloc_tag !== 5'd0) begin
         n_fails++; $display("FAIL flush_after: got empty=%0h count=%0d tag=%0d want 1/0/0", empty, count, alloc_tag);
      end
      @(negedge clk);
   endtask

   task automatic test_full();
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 32'd100 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
         @(negedge clk);
      end
      idle();
      #1;
      n_checks++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 6'd32) begin
         n_fails++; $display("FAIL full_state: got full=%0h ready=%0h count=%0d want 1/0/32", full, alloc_ready, count);
      end
      @(negedge clk);
      applyStimulus(1'b1, 32'd55, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      #1;
      n_checks++; if (rob_wr1_en !== 1'b0) begin n_fails++; $display("FAIL full_no_write: got %0h want 0", rob_wr1_en); end
      repeat (4) @(negedge clk);
      idle();
      #1;
      n_checks++; if (stall_cnt !== STALL_EXP) begin n_fails++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, STALL_EXP); end
      applyStimulus(1'b0, 32'd0, 1'b1, 5'd0, 32'd50, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      #1;
      n_checks++; if (commit_valid !== 1'b1 || alloc_ready !== 1'b0) begin
         n_fails++; $display("FAIL full_commit_no_bypass: got cv=%0h ready=%0h want 1/0", commit_valid, alloc_ready);
      end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 5'd0 || count !== 6'd31 || full !== 1'b0) begin
         n_fails++; $display("FAIL full_after_commit: got ready=%0h tag=%0d count=%0d full=%0h want 1/0/31/0", alloc_ready, alloc_tag, count, full);
      end
      applyStimulus(1'b1, 32'd77, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      #1;
      n_checks++; if (rob_wr1_en !== 1'b1 || rob_wr1_addr !== 5'd0) begin
         n_fails++; $display("FAIL wrap_alloc: got en=%0h addr=%0d want 1/0", rob_wr1_en, rob_wr1_addr);
      end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (count !== 6'd32 || full !== 1'b1) begin n_fails++; $display("FAIL refill: got count=%0d full=%0h want 32/1", count, full); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      applyStimulus(1'b1, 32'd1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      #1;
      n_checks++; if (empty !== 1'b1 || count !== 6'd0 || alloc_tag !== 5'd0 || full !== 1'b0) begin
         n_fails++; $display("FAIL midreset_state: got empty=%0h count=%0d tag=%0d full=%0h want 1/0/0/0", empty, count, alloc_tag, full);
      end
      n_checks++; if (stall_cnt !== 32'd0) begin n_fails++; $display("FAIL midreset_stall: got %0d want 0", stall_cnt); end
      @(negedge clk);
   endtask

   // Watchdog so a stuck run still terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   // Scenario sequence.
   initial begin
      rst = 1'b1;
      idle();
      @(negedge clk);
      test_reset();
      test_alloc();
      test_completion();
      test_dropped_cpl();
      test_commit();
      test_back_to_back();
      test_flush();
      test_full();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
